tap_delay_line: RTL and testbench
=================================

Name: tap_delay_line

Overview:
- Parametrised multi-tap delay line. A chain of DEPTH registered stages, each WIDTH bits wide, carries a valid bit alongside the data.
- A run-time select picks the output: zero delay (bypass) or any stage 1..DEPTH.
- Adds clock enable (stall), flush, fill tracking and out-of-range select detection.
- Used wherever a stream must be aligned against a path of programmable latency.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 3, number of delay stages; legal range 1..64.
- SEL_W, $clog2(DEPTH+1), select width; derived localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  shift enable; when low all stages and the fill counter hold.
- flush  in  1  synchronous clear of all valid bits and the fill counter.
- in_valid  in  1  qualifies d.
- d  in  WIDTH  input sample.
- sel  in  SEL_W  tap select: 0 = bypass; k = output of stage k.
- q  out  WIDTH  selected tap data.
- q_valid  out  1  valid bit of the selected tap.
- primed  out  1  selected tap holds a sample shifted in since the last rst/flush.
- sel_err  out  1  sel > DEPTH.

Behaviour:
- State:
  - data stages s[1..DEPTH] and valid bits v[1..DEPTH];
  - fill_cnt, SEL_W bits wide, saturating at DEPTH.
- Priority per cycle: rst > flush > en.
- rst = 1: all s and v cleared to 0; fill_cnt = 0.
- flush = 1, rst = 0:
  - all v cleared to 0, including the sample entering this cycle; fill_cnt = 0.
  - If en = 1 the data stages still shift, so s[1] <= d. Data contents are retained, not zeroed.
- en = 1, flush = 0, rst = 0:
  - s[1] <= d, v[1] <= in_valid;
  - s[k] <= s[k-1], v[k] <= v[k-1] for k = 2..DEPTH;
  - fill_cnt <= min(fill_cnt + 1, DEPTH).
- en = 0: everything holds. Stage k then delays by k enabled cycles, not k clocks.
- Output mux (combinational, default build):
  - sel = 0: q = d, q_valid = in_valid, primed = 1.
  - 1 <= sel <= DEPTH: q = s[sel], q_valid = v[sel], primed = (fill_cnt >= sel).
  - sel > DEPTH (only possible when DEPTH+1 is not a power of two): q = 0, q_valid = 0, primed = 0, sel_err = 1. Otherwise sel_err = 0.
- Latency: sel = k gives exactly k enabled cycles from d to q; sel = 0 gives 0 cycles.
- A change of sel takes effect in the same cycle with no flush. Stage contents are unaffected by sel.
- Reset values: q = 0 unless sel = 0 (bypass shows d); q_valid = in_valid when sel = 0, else 0; primed = 1 when sel = 0, else 0.
- DEPTH = 1: single stage; fill_cnt saturates at 1.

Optional Feature:
- Macro: TAP_DELAY_LINE_OUT_REG_EN.
- Defined:
  - q, q_valid, primed and sel_err are registered, adding exactly one clk of latency on top of the tap delay.
  - The output register updates every clock, independent of en.
  - It is cleared to 0 by rst and is not affected by flush.
  - Bypass (sel = 0) becomes one cycle.
- Undefined: outputs are combinational as described above.

Decomposition:
- Shared package tap_delay_pkg:
  - clog2 helper function;
  - DEPTH_MAX = 64 constant;
  - a typedef-free parameter check used by elaboration assertions (DEPTH in 1..DEPTH_MAX).
- Sub-module tap_delay_stage: one WIDTH-bit data register plus valid bit, with ports clk, rst, en, clr_valid, d_in, v_in, d_out, v_out. It is instantiated DEPTH times in a generate loop.
- Top level holds fill_cnt, the output mux and the optional output register.

Test Plan:
- Reset then stream: WIDTH = 8, DEPTH = 3, sel = 3, en = 1, in_valid = 1, d = 0x11, 0x22, 0x33, 0x44 on successive cycles -> q = 0x11 with q_valid = 1 and primed = 1 in the 3rd cycle after 0x11 entered; q_valid = 0 and primed = 0 before that.
- Stall: sel = 2; load 0xA5 then 0x5A; drop en for 4 cycles -> q frozen at 0xA5 for all 4 cycles; after en returns, 0x5A appears one enabled cycle later.
- Flush: pipe full of valid data, sel = 3; assert flush with en = 1 and d = 0x77 -> next cycle q_valid = 0, primed = 0, and s[1] = 0x77 with v[1] = 0; primed returns 3 enabled cycles later.
- Select sweep: fill with 0x01, 0x02, 0x03, hold en = 0, d = 0x0F, sel = 0, 1, 2, 3 -> q = 0x0F, 0x03, 0x02, 0x01 combinationally; with DEPTH = 4 and sel = 5 -> q = 0, q_valid = 0, sel_err = 1.
- Priority: assert rst, flush and en together with d = 0xFF, in_valid = 1 -> all stages 0, fill_cnt = 0. A mid-stream rst gives q = 0 for sel != 0 on the next cycle.
- Macro build (TAP_DELAY_LINE_OUT_REG_EN): repeat scenario 1 -> 0x11 appears one cycle later than in the default build; sel = 0 gives d delayed by 1 clk.

Source files
------------

// File: rtl/tap_delay_pkg.sv
// -----------------------------------------------------------------------------
// tap_delay_pkg
// Shared constants and helpers for the tap_delay_line slice.
//   DEPTH_MAX : largest supported number of delay stages
//   clog2()   : ceiling log2, used to size the tap select and fill counter
//   depth_ok(): elaboration-time legality check for the DEPTH parameter
// -----------------------------------------------------------------------------
package tap_delay_pkg;

  localparam int DEPTH_MAX = 64;

  // Number of bits needed to encode values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 1) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/tap_delay_stage.sv
// -----------------------------------------------------------------------------
// tap_delay_stage
// One stage of the tap delay line: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears data and valid
//   en        : shift enable; data and valid load only when high
//   clr_valid : clears the valid bit regardless of en (flush); data still
//               shifts when en is high
//   d_in/v_in : data/valid from the previous stage (or the line input)
//   d_out/v_out : registered data/valid of this stage
// -----------------------------------------------------------------------------
module tap_delay_stage
  import tap_delay_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
      v_out <= 1'b0;
    end else begin
      // Flush only kills the qualifier; the sample itself keeps moving.
      if (en) d_out <= d_in;
      if (clr_valid)  v_out <= 1'b0;
      else if (en)    v_out <= v_in;
    end
  end

endmodule

// File: rtl/tap_delay_line.sv
// -----------------------------------------------------------------------------
// tap_delay_line
// Parametrised multi-tap delay line with run-time tap select, stall, flush,
// fill tracking and out-of-range select detection.
// Parameters:
//   WIDTH : data width
//   DEPTH : number of delay stages (1..DEPTH_MAX)
//   SEL_W : derived select / fill counter width, clog2(DEPTH+1)
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   en         : shift enable (stall when low)
//   flush      : clears all valid bits and the fill counter
//   in_valid,d : input sample and its qualifier
//   sel        : 0 = bypass, k = output of stage k
//   q, q_valid : selected tap data and valid
//   primed     : selected tap holds a sample shifted in since last rst/flush
//   sel_err    : sel > DEPTH
// Build option:
//   TAP_DELAY_LINE_OUT_REG_EN : register q/q_valid/primed/sel_err, adding one
//   clk of latency; the register runs every clock, ignores en and flush, and
//   is cleared by rst.
// -----------------------------------------------------------------------------
module tap_delay_line
  import tap_delay_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int SEL_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             primed,
  output logic             sel_err
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("tap_delay_line: DEPTH must be in 1..%0d", DEPTH_MAX);
  end

  // Fill counter saturates at DEPTH so it never wraps in a long stream.
  function automatic logic [SEL_W-1:0] fill_sat_inc(input logic [SEL_W-1:0] c);
    return (c >= SEL_W'(DEPTH)) ? c : c + SEL_W'(1);
  endfunction

  // Index 0 is the line input, so a tap select maps directly onto the array.
  logic [WIDTH-1:0] s_p0 [0:DEPTH];
  logic             vld_p0 [0:DEPTH];
  logic [SEL_W-1:0] fill_cnt;

  assign s_p0[0]   = d;
  assign vld_p0[0] = in_valid;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    tap_delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr_valid (flush),
      .d_in      (s_p0[k-1]),
      .v_in      (vld_p0[k-1]),
      .d_out     (s_p0[k]),
      .v_out     (vld_p0[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)        fill_cnt <= '0;
    else if (flush) fill_cnt <= '0;
    else if (en)    fill_cnt <= fill_sat_inc(fill_cnt);
  end

  // ---- tap select mux (combinational) ----
  logic [WIDTH-1:0] q_p0;
  logic             qvld_p0;
  logic             primed_p0;
  logic             err_p0;

  always_comb begin
    q_p0      = '0;
    qvld_p0   = 1'b0;
    primed_p0 = 1'b0;
    err_p0    = 1'b0;
    if (sel == '0) begin
      q_p0      = d;
      qvld_p0   = in_valid;
      primed_p0 = 1'b1;
    end else if (sel > SEL_W'(DEPTH)) begin
      err_p0    = 1'b1;
    end else begin
      q_p0      = s_p0[sel];
      qvld_p0   = vld_p0[sel];
      primed_p0 = (fill_cnt >= sel);
    end
  end

`ifdef TAP_DELAY_LINE_OUT_REG_EN
  // ---- output register stage ----
  logic [WIDTH-1:0] q_p1;
  logic             qvld_p1;
  logic             primed_p1;
  logic             err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_p1      <= '0;
      qvld_p1   <= 1'b0;
      primed_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      q_p1      <= q_p0;
      qvld_p1   <= qvld_p0;
      primed_p1 <= primed_p0;
      err_p1    <= err_p0;
    end
  end

  assign q       = q_p1;
  assign q_valid = qvld_p1;
  assign primed  = primed_p1;
  assign sel_err = err_p1;
`else
  assign q       = q_p0;
  assign q_valid = qvld_p0;
  assign primed  = primed_p0;
  assign sel_err = err_p0;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// -----------------------------------------------------------------------------
// tb_tap_delay_line
// Drives two tap_delay_line instances (DEPTH = 3 and DEPTH = 4) from the same
// input stream with independent tap selects and compares every output against
// a history-based reference model: the k-th tap is simply the k-th most recent
// enabled sample. Honours TAP_DELAY_LINE_OUT_REG_EN by delaying the model's
// expectation by one clock.
// -----------------------------------------------------------------------------
module tb_tap_delay_line;

  localparam int W = 8;
  localparam int HMAX = 65;

  logic         clk = 1'b0;
  logic         rst, en, flush, in_valid;
  logic [W-1:0] d;
  logic [1:0]   sel3;
  logic [2:0]   sel4;
  logic [W-1:0] q3, q4;
  logic         qv3, qv4, pr3, pr4, err3, err4;

  always #5 clk = ~clk;

  tap_delay_line #(.WIDTH(W), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
    .sel(sel3), .q(q3), .q_valid(qv3), .primed(pr3), .sel_err(err3));

  tap_delay_line #(.WIDTH(W), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
    .sel(sel4), .q(q4), .q_valid(qv4), .primed(pr4), .sel_err(err4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of enabled samples, newest first.
  logic [W-1:0] hist_d [HMAX];
  logic         hist_v [HMAX];
  int           pushes;  // enabled samples since last rst/flush (unbounded)

  typedef struct packed {
    logic [W-1:0] q;
    logic         qv;
    logic         pr;
    logic         err;
  } out_t;

  out_t reg3 = '0, reg4 = '0;

  function automatic out_t model_out(input int k, input int depth);
    out_t o;
    o = '0;
    if (k == 0) begin
      o.q = d; o.qv = in_valid; o.pr = 1'b1;
    end else if (k > depth) begin
      o.err = 1'b1;
    end else begin
      o.q = hist_d[k-1]; o.qv = hist_v[k-1]; o.pr = (pushes >= k);
    end
    return o;
  endfunction

  task automatic compare(input string name, input out_t e, input logic [W-1:0] gq,
                         input logic gv, input logic gp, input logic ge);
    check({name, ".q"},       32'(gq), 32'(e.q));
    check({name, ".q_valid"}, 32'(gv), 32'(e.qv));
    check({name, ".primed"},  32'(gp), 32'(e.pr));
    check({name, ".sel_err"}, 32'(ge), 32'(e.err));
  endtask

  // One clock: apply inputs, check before the edge, advance the model.
  task automatic cycle(input logic r, input logic f, input logic e, input logic iv,
                       input logic [W-1:0] dd, input int s3, input int s4);
    out_t c3, c4;
    rst = r; flush = f; en = e; in_valid = iv; d = dd;
    sel3 = 2'(s3); sel4 = 3'(s4);
    @(negedge clk);
    c3 = model_out(s3, 3);
    c4 = model_out(s4, 4);
`ifdef TAP_DELAY_LINE_OUT_REG_EN
    compare("d3", reg3, q3, qv3, pr3, err3);
    compare("d4", reg4, q4, qv4, pr4, err4);
`else
    compare("d3", c3, q3, qv3, pr3, err3);
    compare("d4", c4, q4, qv4, pr4, err4);
`endif
    @(posedge clk);
    reg3 = r ? '0 : c3;
    reg4 = r ? '0 : c4;
    if (r) begin
      for (int i = 0; i < HMAX; i++) begin hist_d[i] = '0; hist_v[i] = 1'b0; end
      pushes = 0;
    end else begin
      if (f) begin
        for (int i = 0; i < HMAX; i++) hist_v[i] = 1'b0;
        pushes = 0;
      end
      if (e) begin
        for (int i = HMAX - 1; i > 0; i--) begin
          hist_d[i] = hist_d[i-1]; hist_v[i] = hist_v[i-1];
        end
        hist_d[0] = dd;
        hist_v[0] = f ? 1'b0 : iv;
        if (!f) pushes++;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) begin hist_d[i] = '0; hist_v[i] = 1'b0; end
    pushes = 0;
    rst = 1'b1; flush = 1'b0; en = 1'b0; in_valid = 1'b0; d = '0; sel3 = '0; sel4 = '0;
    @(posedge clk); #1;

    // Reset state, bypass and tapped selects.
    cycle(1, 0, 1, 1, 8'h99, 0, 0);
    cycle(1, 0, 1, 1, 8'h98, 3, 4);

    // Reset then stream into tap 3.
    cycle(0, 0, 1, 1, 8'h11, 3, 3);
    cycle(0, 0, 1, 1, 8'h22, 3, 3);
    cycle(0, 0, 1, 1, 8'h33, 3, 3);
    cycle(0, 0, 1, 1, 8'h44, 3, 3);
    cycle(0, 0, 1, 1, 8'h55, 3, 3);

    // Stall on tap 2.
    cycle(0, 0, 1, 1, 8'hA5, 2, 2);
    cycle(0, 0, 1, 1, 8'h5A, 2, 2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'hEE, 2, 2);
    cycle(0, 0, 1, 1, 8'h3C, 2, 2);
    cycle(0, 0, 1, 1, 8'hC3, 2, 2);

    // Flush with a full pipe, then watch primed return.
    cycle(0, 1, 1, 1, 8'h77, 3, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 8'(8'h80 + i), 3, 1);

    // Select sweep with the line stalled; DEPTH=4 also sees sel 5..7.
    cycle(0, 0, 1, 1, 8'h01, 0, 0);
    cycle(0, 0, 1, 1, 8'h02, 0, 0);
    cycle(0, 0, 1, 1, 8'h03, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 8'h0F, i % 4, i);

    // Priority: rst beats flush beats en.
    cycle(0, 0, 1, 1, 8'h42, 1, 1);
    cycle(1, 1, 1, 1, 8'hFF, 1, 2);
    cycle(0, 0, 0, 0, 8'h00, 1, 1);
    cycle(0, 1, 0, 1, 8'h10, 1, 1);
    cycle(0, 0, 1, 1, 8'h20, 1, 1);

    // Randomised stream.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
